// File: rtl/acc_points_num_cluster_bank.sv
// rtl/acc_points_num_cluster_bank.sv - per-cluster saturating point counters with valid/ready readout
module acc_points_num_cluster_bank #(
    parameter int N_CLUSTERS = 16,
    parameter int ID_W       = 4,
    parameter int CNT_W      = 11
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ce,
    input  logic              i_pt_valid,
    input  logic [ID_W-1:0]   i_pt_id,
    input  logic              i_frame_end,
    output logic              o_busy,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ID_W-1:0]   o_out_id,
    output logic [CNT_W-1:0]  o_out_count,
    output logic              o_out_sat,
    output logic              o_out_last,
    output logic              o_err_id,
    output logic              o_err_drop
);

    localparam logic [ID_W:0]    LP_N    = (ID_W+1)'(N_CLUSTERS);
    localparam logic [ID_W-1:0]  LP_LAST = ID_W'(N_CLUSTERS - 1);
    localparam logic [CNT_W-1:0] LP_MAX  = {CNT_W{1'b1}};

    typedef enum logic {ST_ACC, ST_DUMP} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt [N_CLUSTERS];
    logic [ID_W-1:0]  r_idx;
    logic             r_busy;
    logic             r_out_valid;
    logic [ID_W-1:0]  r_out_id;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_sat;
    logic             r_out_last;
    logic             r_err_id;
    logic             r_err_drop;

    logic             w_pt_ok;
    logic             w_inc_en;
    logic             w_xfer;
    logic [ID_W-1:0]  w_idx_nxt;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic [CNT_W-1:0] w_cnt0_nxt;

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
        return (v == LP_MAX) ? v : v + 1'b1;
    endfunction

    assign w_pt_ok   = {1'b0, i_pt_id} < LP_N;
    assign w_inc_en  = i_ce && (r_state == ST_ACC) && i_pt_valid && w_pt_ok;
    assign w_xfer    = i_ce && (r_state == ST_DUMP) && r_out_valid && i_out_ready;
    assign w_idx_nxt = r_idx + 1'b1;

    // First readout word must already include a point arriving alongside frame_end.
    assign w_cnt0_nxt = (w_inc_en && (i_pt_id == '0)) ? f_sat_inc(r_cnt[0]) : r_cnt[0];

    always_comb begin
        w_nxt_cnt = '0;
        if ({1'b0, w_idx_nxt} < LP_N)
            w_nxt_cnt = r_cnt[w_idx_nxt];
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < N_CLUSTERS; i++) begin
            if (i_rst)
                r_cnt[i] <= '0;
            else if (w_inc_en && (i_pt_id == ID_W'(i)))
                r_cnt[i] <= f_sat_inc(r_cnt[i]);
            else if (w_xfer && (r_idx == ID_W'(i)))
                r_cnt[i] <= '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_ACC;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
            r_out_last  <= 1'b0;
            r_err_id    <= 1'b0;
            r_err_drop  <= 1'b0;
        end else if (i_ce) begin
            case (r_state)
                ST_ACC: begin
                    if (i_pt_valid && !w_pt_ok)
                        r_err_id <= 1'b1;
                    if (i_frame_end) begin
                        r_state     <= ST_DUMP;
                        r_idx       <= '0;
                        r_busy      <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_out_id    <= '0;
                        r_out_count <= w_cnt0_nxt;
                        r_out_sat   <= (w_cnt0_nxt == LP_MAX);
                        r_out_last  <= (LP_LAST == '0);
                    end
                end
                ST_DUMP: begin
                    if (i_pt_valid || i_frame_end)
                        r_err_drop <= 1'b1;
                    if (r_out_valid && i_out_ready) begin
                        if (r_out_last) begin
                            r_state     <= ST_ACC;
                            r_idx       <= '0;
                            r_busy      <= 1'b0;
                            r_out_valid <= 1'b0;
                            r_out_id    <= '0;
                            r_out_count <= '0;
                            r_out_sat   <= 1'b0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_idx       <= w_idx_nxt;
                            r_out_id    <= w_idx_nxt;
                            r_out_count <= w_nxt_cnt;
                            r_out_sat   <= (w_nxt_cnt == LP_MAX);
                            r_out_last  <= (w_idx_nxt == LP_LAST);
                        end
                    end
                end
                default: r_state <= ST_ACC;
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_out_valid = r_out_valid;
    assign o_out_id    = r_out_id;
    assign o_out_count = r_out_count;
    assign o_out_sat   = r_out_sat;
    assign o_out_last  = r_out_last;
    assign o_err_id    = r_err_id;
    assign o_err_drop  = r_err_drop;

endmodule

// File: tb/tb_acc_points_num_cluster_bank.sv
// tb/tb_acc_points_num_cluster_bank.sv - scoreboard bench for acc_points_num_cluster_bank
module tb_acc_points_num_cluster_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce  = 1'b1;
    logic        pt_valid = 1'b0;
    logic [3:0]  pt_id = '0;
    logic        frame_end = 1'b0;
    logic        out_ready = 1'b1;
    logic        busy, out_valid, out_sat, out_last, err_id, err_drop;
    logic [3:0]  out_id;
    logic [10:0] out_count;

    logic        b_pt_valid = 1'b0;
    logic [3:0]  b_pt_id = '0;
    logic        b_frame_end = 1'b0;
    logic        b_out_ready = 1'b1;
    logic        b_busy, b_out_valid, b_out_sat, b_out_last, b_err_id, b_err_drop;
    logic [3:0]  b_out_id;
    logic [10:0] b_out_count;

    always #5 clk = ~clk;

    acc_points_num_cluster_bank #(.N_CLUSTERS(16), .ID_W(4), .CNT_W(11)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_pt_valid(pt_valid), .i_pt_id(pt_id),
        .i_frame_end(frame_end), .o_busy(busy), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_out_id(out_id), .o_out_count(out_count),
        .o_out_sat(out_sat), .o_out_last(out_last), .o_err_id(err_id), .o_err_drop(err_drop)
    );

    acc_points_num_cluster_bank #(.N_CLUSTERS(12), .ID_W(4), .CNT_W(11)) u_dut12 (
        .i_clk(clk), .i_rst(rst), .i_ce(1'b1), .i_pt_valid(b_pt_valid), .i_pt_id(b_pt_id),
        .i_frame_end(b_frame_end), .o_busy(b_busy), .o_out_valid(b_out_valid),
        .i_out_ready(b_out_ready), .o_out_id(b_out_id), .o_out_count(b_out_count),
        .o_out_sat(b_out_sat), .o_out_last(b_out_last), .o_err_id(b_err_id),
        .o_err_drop(b_err_drop)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [10:0] cnt;
        logic        sat;
        logic        last;
    } word_t;

    word_t sb[$];
    int    m_cnt[16];
    int    n_chk = 0;
    int    n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expected word per accepted transfer, checks holds otherwise.
    logic        hold = 1'b0;
    logic [18:0] prev = '0;
    always @(negedge clk) begin
        word_t w;
        if (!rst) begin
            if (hold)
                chk("hold_stable", {13'd0, out_valid, out_id, out_count, out_sat, out_last}, {13'd0, prev});
            if (out_valid && out_ready && ce) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 32'd1, 32'd0);
                end else begin
                    w = sb.pop_front();
                    chk("word_id", 32'(out_id), 32'(w.id));
                    chk("word_count", 32'(out_count), 32'(w.cnt));
                    chk("word_sat", 32'(out_sat), 32'(w.sat));
                    chk("word_last", 32'(out_last), 32'(w.last));
                end
                hold = 1'b0;
            end else begin
                hold = out_valid;
                prev = {out_valid, out_id, out_count, out_sat, out_last};
            end
        end else begin
            hold = 1'b0;
        end
    end

    task automatic send_pt(input int id);
        pt_valid = 1'b1;
        pt_id    = 4'(id);
        if (m_cnt[id] < 2047) m_cnt[id]++;
        step();
        pt_valid = 1'b0;
    endtask

    task automatic end_frame(input bit with_pt, input int id);
        word_t w;
        frame_end = 1'b1;
        if (with_pt) begin
            pt_valid = 1'b1;
            pt_id    = 4'(id);
            if (m_cnt[id] < 2047) m_cnt[id]++;
        end
        step();
        frame_end = 1'b0;
        pt_valid  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w.id   = 4'(i);
            w.cnt  = 11'(m_cnt[i]);
            w.sat  = (m_cnt[i] == 2047);
            w.last = (i == 15);
            sb.push_back(w);
            m_cnt[i] = 0;
        end
    endtask

    task automatic wait_idle(input bit rnd, output int n);
        n = 0;
        while (busy && n < 400) begin
            if (rnd) begin
                out_ready = 1'($urandom_range(0, 1));
                ce        = 1'($urandom_range(0, 1));
            end
            step();
            n++;
        end
        ce        = 1'b1;
        out_ready = 1'b1;
        if (n >= 400) chk("dump_timeout", 32'd1, 32'd0);
        step();
        chk("all_words_seen", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) m_cnt[i] = 0;
        step();
        step();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_id", 32'(out_id), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_sat_last", {30'd0, out_sat, out_last}, 32'd0);
        chk("rst_errs", {30'd0, err_id, err_drop}, 32'd0);

        // Basic frame and busy duration
        for (int i = 0; i < 5; i++) send_pt(3);
        for (int i = 0; i < 2; i++) send_pt(0);
        end_frame(1'b0, 0);
        chk("busy_after_fe", 32'(busy), 32'd1);
        wait_idle(1'b0, n);
        chk("busy_cycles", 32'(n), 32'd16);

        // Saturation, then a fresh frame
        for (int i = 0; i < 2050; i++) send_pt(7);
        end_frame(1'b0, 0);
        wait_idle(1'b0, n);
        send_pt(7);
        end_frame(1'b0, 0);
        wait_idle(1'b0, n);

        // Random backpressure and clock enable
        for (int i = 0; i < 3; i++) send_pt(1);
        send_pt(15);
        for (int i = 0; i < 2; i++) send_pt(8);
        end_frame(1'b0, 0);
        wait_idle(1'b1, n);
        chk("err_drop_clean", 32'(err_drop), 32'd0);

        // Point with frame_end counted, point during DUMP dropped
        send_pt(3);
        end_frame(1'b1, 3);
        pt_valid = 1'b1;
        pt_id    = 4'd3;
        step();
        pt_valid = 1'b0;
        wait_idle(1'b0, n);
        chk("err_drop_set", 32'(err_drop), 32'd1);
        chk("err_id_main", 32'(err_id), 32'd0);

        // Reset mid-readout
        for (int i = 0; i < 3; i++) send_pt(9);
        end_frame(1'b0, 0);
        for (int i = 0; i < 5; i++) step();
        chk("dump_word5_id", 32'(out_id), 32'd5);
        rst = 1'b1;
        step();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_id_count", {17'd0, out_id, out_count}, 32'd0);
        chk("abort_sat_last", {30'd0, out_sat, out_last}, 32'd0);
        chk("abort_errs", {30'd0, err_id, err_drop}, 32'd0);
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 16; i++) m_cnt[i] = 0;
        send_pt(2);
        end_frame(1'b0, 0);
        wait_idle(1'b0, n);

        // Out-of-range id on a 12-cluster bank
        chk("b_err_id_init", 32'(b_err_id), 32'd0);
        b_pt_valid = 1'b1;
        b_pt_id    = 4'd15;
        step();
        chk("b_err_id_set", 32'(b_err_id), 32'd1);
        b_pt_id = 4'd2;
        step();
        b_pt_valid  = 1'b0;
        b_frame_end = 1'b1;
        step();
        b_frame_end = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("b_valid", 32'(b_out_valid), 32'd1);
            chk("b_id", 32'(b_out_id), 32'(k));
            chk("b_count", 32'(b_out_count), (k == 2) ? 32'd1 : 32'd0);
            chk("b_last", 32'(b_out_last), (k == 11) ? 32'd1 : 32'd0);
            step();
        end
        chk("b_busy_done", 32'(b_busy), 32'd0);
        chk("b_err_drop", 32'(b_err_drop), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
